ext_mem_host_ctrl: RTL and testbench
====================================

# ext_mem_host_ctrl

Host-side sequencer that drives the CPU's external memory ports and its `enable` input. It accepts commands from a test or host stream to:
- load instruction memory,
- load data memory,
- run the CPU for a fixed cycle count,
- dump data memory back out.

It is the initiator for the instruction and data SRAM external ports (`addr_ext*`, `wen_ext*`, `ren_ext*`, `wdata_ext*`, `rdata_ext_2`). It sits between the host stream interface and the `cpu` top.

## Interface
Parameters:
- `IMEM_WORDS`, 128: instruction memory depth in 32-bit words; byte stride 4.
- `DMEM_WORDS`, 128: data memory depth in 64-bit words; byte stride 8.

Ports:
- `clk`  in  1  clock. One clock; reset is synchronous and active-low.
- `arst_n`  in  1  synchronous active-low reset, sampled on the rising edge of `clk`.
- `cmd_valid` / `cmd_ready`  in/out  1/1  command handshake.
- `cmd_op`  in  2  command opcode: 00 LOAD_I, 01 LOAD_D, 10 RUN, 11 DUMP_D.
- `cmd_len`  in  32  word count (loads/dump) or cycle count (RUN).
- `abort`  in  1  return to IDLE next cycle.
- `wr_valid` / `wr_ready` / `wr_data`  in/out/in  1/1/64  load data stream.
- `rd_valid` / `rd_ready` / `rd_data`  out/in/out  1/1/64  dump data stream.
- `addr_ext` / `wen_ext` / `ren_ext` / `wdata_ext`  out  64/1/1/32  instruction SRAM external port.
- `addr_ext_2` / `wen_ext_2` / `ren_ext_2` / `wdata_ext_2`  out  64/1/1/64  data SRAM external port.
- `rdata_ext_2`  in  64  data SRAM read data; valid the cycle after `ren_ext_2`.
- `cpu_enable`  out  1  drives the CPU `enable` input.
- `busy` / `done` / `err`  out  1/1/1  status; `done` and `err` are single-cycle pulses.

## Operation
- States: IDLE, LOAD, RD_REQ, RD_WAIT, RD_OUT, RUN, FIN.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch `op`, `len`, and word index `idx`=0, then go to:
  - LOAD for LOAD_I or LOAD_D,
  - RD_REQ for DUMP_D,
  - RUN for RUN.
- Degenerate commands go to FIN directly:
  - `cmd_len`==0 → FIN.
  - `cmd_len` > depth on a load/dump → FIN with `err`.
  - Neither case produces any memory strobe.
- LOAD:
  - `wr_ready`=1.
  - Each handshake registers one write: address = `idx`*stride, data = `wr_data` (low 32 bits for LOAD_I); `idx` increments.
  - After handshake number `len`, go to FIN.
- RD_REQ: pulse `ren_ext_2` with `addr_ext_2`=`idx`*8, then go to RD_WAIT.
- RD_WAIT: capture `rdata_ext_2` into `rd_data`, then go to RD_OUT.
- RD_OUT:
  - `rd_valid`=1; `rd_data` is held stable until `rd_ready`.
  - On handshake, `idx` increments, then go to RD_REQ, or to FIN if `idx`==`len`-1.
- RUN:
  - `cpu_enable`=1 while the cycle counter is below `len`; the counter increments each cycle.
  - Go to FIN when the counter reaches `len`.
- FIN: pulse `done` (plus `err` if flagged), then go to IDLE.
- `ren_ext` is constant 0. Instruction memory is never read back.
- Exclusivity: no external strobe is ever asserted in a cycle where `cpu_enable`=1. `wen_ext` and `wen_ext_2` are never high together.
- Counters are 32-bit and never wrap, because `len` is bounded by the checks above.

## Timing
- All outputs are registered except `cmd_ready`, `wr_ready` and `rd_valid`, which decode directly from state.
- Reset (`arst_n`=0 at an edge): state IDLE; `idx` and counter 0; every output 0 except `cmd_ready`=1. Reset mid-LOAD or mid-RUN has the same effect, and `cpu_enable` drops the next cycle.
- Command accepted at cycle N: first state action at N+1; `busy`=1 from N+1 through the FIN cycle.
- LOAD: handshake at cycle M → `wen_ext`/`wen_ext_2` high for exactly cycle M+1 with the matching address and data.
  - Back-to-back loads run at 1 word/cycle.
  - `done` at M+2 after the last word.
- DUMP: `ren_ext_2` at R; `rd_valid` from R+2; next `ren_ext_2` the cycle after the `rd_ready` handshake. Zero stall gives 3 cycles/word.
- RUN: `cpu_enable` high for exactly `len` consecutive cycles N+1..N+len; `done` at N+len+1.
- Degenerate command: `done` (and `err` if flagged) at N+1.
- `abort` at cycle A in any non-IDLE state: IDLE at A+1, with all strobes, `cpu_enable`, `rd_valid` and `wr_ready` low. No `done` pulse. Ignored in IDLE.
- Simultaneous `abort` and reset: reset wins; the resulting state is the same.

## Test plan
- LOAD_I, `len`=3, words 0x13, 0x00A00093, 0x002081B3 streamed back-to-back → `wen_ext` high 3 consecutive cycles, `addr_ext` 0/4/8, `wdata_ext` matches each word, `done` 2 cycles after the last handshake.
- LOAD_D, `len`=2, with `wr_valid` gaps of 2 cycles → `wen_ext_2` pulses only on handshakes, `addr_ext_2` 0/8, `wdata_ext_2` carries the full 64 bits.
- RUN `len`=10 → `cpu_enable` high exactly 10 cycles, no strobes, `done` the cycle after; `len`=0 → `done` at N+1, `cpu_enable` never high.
- DUMP_D `len`=2 with a memory model returning 0xDEAD/0xBEEF and `rd_ready` low for 4 cycles → `rd_data` held stable while stalled, words delivered in order, `ren_ext_2` never re-issued while `rd_valid`=1.
- LOAD_I `len`=129 (default `IMEM_WORDS`) → `err` and `done` at N+1, no `wen_ext`.
- Abort mid-RUN at cycle 5, and reset mid-LOAD → `cpu_enable`/`wen_ext` low next cycle, no `done`, `cmd_ready`=1; the next command executes normally.

Source files
------------

// File: rtl/ext_mem_host_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ext_mem_host_ctrl_if
//  Purpose  : Host-side stream bundle for ext_mem_host_ctrl: the command
//             handshake, abort, load/dump data streams and status pulses.
//  Revision : 1.0  initial release
// ============================================================================
interface ext_mem_host_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_len;
  logic        abort;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [63:0] rd_data;
  logic        busy;
  logic        done;
  logic        err;

  // Host / test stream side
  modport master (
    output cmd_valid, cmd_op, cmd_len, abort, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_len, abort, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/ext_mem_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ext_mem_host_ctrl
//  Purpose  : Host sequencer for the CPU external SRAM ports: loads
//             instruction/data memory, runs the CPU for N cycles and dumps
//             data memory back to the host stream.
//  Revision : 1.0  initial release
// ============================================================================
module ext_mem_host_ctrl #(
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_WORDS = 128
) (
  input  wire logic              clk,
  input  wire logic              arst_n,
  ext_mem_host_ctrl_if.slave     host,
  output logic        [63:0]     addr_ext,
  output logic                   wen_ext,
  output logic                   ren_ext,
  output logic        [31:0]     wdata_ext,
  output logic        [63:0]     addr_ext_2,
  output logic                   wen_ext_2,
  output logic                   ren_ext_2,
  output logic        [63:0]     wdata_ext_2,
  input  wire logic   [63:0]     rdata_ext_2,
  output logic                   cpu_enable
);

  localparam logic [1:0]  c_op_load_i  = 2'b00;
  localparam logic [1:0]  c_op_load_d  = 2'b01;
  localparam logic [1:0]  c_op_run     = 2'b10;
  localparam logic [1:0]  c_op_dump_d  = 2'b11;
  localparam logic [31:0] c_imem_depth = 32'(IMEM_WORDS);
  localparam logic [31:0] c_dmem_depth = 32'(DMEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RD_OUT  = 3'd4,
    S_RUN     = 3'd5,
    S_FIN     = 3'd6
  } state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [31:0] r_len;
  logic [31:0] r_idx;
  logic [31:0] r_cnt;
  logic        r_fin_wait;   // loads hold FIN one extra cycle so done trails the last write
  logic [63:0] r_rd_data;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic [31:0] w_depth;
  logic [31:0] w_idx_inc;
  logic        w_idx_last;
  logic        w_cnt_last;

  assign w_depth    = (host.cmd_op == c_op_load_i) ? c_imem_depth : c_dmem_depth;
  assign w_idx_inc  = r_idx + 32'd1;
  assign w_idx_last = (r_idx == r_len - 32'd1);
  assign w_cnt_last = (r_cnt == r_len - 32'd1);

  // Handshake readiness decodes straight from state; everything else is registered
  assign host.cmd_ready = (r_state == S_IDLE);
  assign host.wr_ready  = (r_state == S_LOAD);
  assign host.rd_valid  = (r_state == S_RD_OUT);
  assign host.rd_data   = r_rd_data;
  assign host.busy      = r_busy;
  assign host.done      = r_done;
  assign host.err       = r_err;

  // Instruction memory is write-only from the host side
  assign ren_ext = 1'b0;

  // Sequencer FSM with registered memory strobes, status and CPU enable
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state     <= S_IDLE;
      r_op        <= 2'b00;
      r_len       <= 32'd0;
      r_idx       <= 32'd0;
      r_cnt       <= 32'd0;
      r_fin_wait  <= 1'b0;
      r_rd_data   <= 64'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      addr_ext    <= 64'd0;
      wen_ext     <= 1'b0;
      wdata_ext   <= 32'd0;
      addr_ext_2  <= 64'd0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      wdata_ext_2 <= 64'd0;
      cpu_enable  <= 1'b0;
    end else begin
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      ren_ext_2 <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      if (host.abort && (r_state != S_IDLE)) begin
        r_state    <= S_IDLE;
        r_fin_wait <= 1'b0;
        r_busy     <= 1'b0;
        cpu_enable <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (host.cmd_valid) begin
              r_op       <= host.cmd_op;
              r_len      <= host.cmd_len;
              r_idx      <= 32'd0;
              r_cnt      <= 32'd0;
              r_fin_wait <= 1'b0;
              r_busy     <= 1'b1;
              if (host.cmd_len == 32'd0) begin
                r_state <= S_FIN;
                r_done  <= 1'b1;
              end else if ((host.cmd_op != c_op_run) && (host.cmd_len > w_depth)) begin
                r_state <= S_FIN;
                r_done  <= 1'b1;
                r_err   <= 1'b1;
              end else begin
                case (host.cmd_op)
                  c_op_load_i, c_op_load_d: r_state <= S_LOAD;
                  c_op_dump_d: begin
                    r_state    <= S_RD_REQ;
                    ren_ext_2  <= 1'b1;
                    addr_ext_2 <= 64'd0;
                  end
                  default: begin
                    r_state    <= S_RUN;
                    cpu_enable <= 1'b1;
                  end
                endcase
              end
            end
          end
          S_LOAD: begin
            if (host.wr_valid) begin
              if (r_op == c_op_load_i) begin
                wen_ext   <= 1'b1;
                addr_ext  <= {30'd0, r_idx, 2'b00};
                wdata_ext <= host.wr_data[31:0];
              end else begin
                wen_ext_2   <= 1'b1;
                addr_ext_2  <= {29'd0, r_idx, 3'b000};
                wdata_ext_2 <= host.wr_data;
              end
              r_idx <= w_idx_inc;
              if (w_idx_last) begin
                r_state    <= S_FIN;
                r_fin_wait <= 1'b1;
              end
            end
          end
          S_RD_REQ: r_state <= S_RD_WAIT;
          S_RD_WAIT: begin
            r_rd_data <= rdata_ext_2;
            r_state   <= S_RD_OUT;
          end
          S_RD_OUT: begin
            if (host.rd_ready) begin
              r_idx <= w_idx_inc;
              if (w_idx_last) begin
                r_state <= S_FIN;
                r_done  <= 1'b1;
              end else begin
                r_state    <= S_RD_REQ;
                ren_ext_2  <= 1'b1;
                addr_ext_2 <= {29'd0, w_idx_inc, 3'b000};
              end
            end
          end
          S_RUN: begin
            r_cnt <= r_cnt + 32'd1;
            if (w_cnt_last) begin
              r_state    <= S_FIN;
              cpu_enable <= 1'b0;
              r_done     <= 1'b1;
            end
          end
          S_FIN: begin
            if (r_fin_wait) begin
              r_fin_wait <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ext_mem_host_ctrl
//  Purpose  : Directed self-checking bench for ext_mem_host_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ext_mem_host_ctrl;

  logic        clk;
  logic        arst_n;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;
  logic        cpu_enable;

  int n_checks = 0;
  int n_pass   = 0;

  // Event counters sampled mid-cycle
  int n_wen = 0, n_wen2 = 0, n_ren2 = 0, n_ren_i = 0, n_en = 0, n_done = 0, n_excl = 0;

  logic [63:0] dmem [0:127];

  ext_mem_host_ctrl_if host_if ();

  ext_mem_host_ctrl #(
    .IMEM_WORDS(128),
    .DMEM_WORDS(128)
  ) u_dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .host       (host_if),
    .addr_ext   (addr_ext),
    .wen_ext    (wen_ext),
    .ren_ext    (ren_ext),
    .wdata_ext  (wdata_ext),
    .addr_ext_2 (addr_ext_2),
    .wen_ext_2  (wen_ext_2),
    .ren_ext_2  (ren_ext_2),
    .wdata_ext_2(wdata_ext_2),
    .rdata_ext_2(rdata_ext_2),
    .cpu_enable (cpu_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data SRAM read model: data appears the cycle after ren_ext_2
  always_ff @(posedge clk) begin
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[9:3]];
  end

  // Strobe / enable monitor
  always @(negedge clk) begin
    if (wen_ext)    n_wen++;
    if (wen_ext_2)  n_wen2++;
    if (ren_ext_2)  n_ren2++;
    if (ren_ext)    n_ren_i++;
    if (cpu_enable) n_en++;
    if (host_if.done) n_done++;
    if ((cpu_enable && (wen_ext || wen_ext_2 || ren_ext_2)) || (wen_ext && wen_ext_2)) n_excl++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one cycle; returns in the first cycle after acceptance
  task automatic send_cmd(input logic [1:0] op, input logic [31:0] len);
    host_if.cmd_valid = 1'b1;
    host_if.cmd_op    = op;
    host_if.cmd_len   = len;
    check("cmd_ready_idle", 64'(host_if.cmd_ready), 64'd1);
    tick();
    host_if.cmd_valid = 1'b0;
  endtask

  logic [31:0] imem_words [3];
  logic [63:0] dmem_words [2];
  int snap_wen, snap_wen2, snap_ren2, snap_en, snap_done;

  initial begin
    imem_words[0] = 32'h0000_0013;
    imem_words[1] = 32'h00A0_0093;
    imem_words[2] = 32'h0020_81B3;
    dmem_words[0] = 64'h0123_4567_89AB_CDEF;
    dmem_words[1] = 64'hFEDC_BA98_7654_3210;
    for (int i = 0; i < 128; i++) dmem[i] = 64'd0;
    dmem[0] = 64'hDEAD;
    dmem[1] = 64'hBEEF;

    arst_n            = 1'b0;
    host_if.cmd_valid = 1'b0;
    host_if.cmd_op    = 2'b00;
    host_if.cmd_len   = 32'd0;
    host_if.abort     = 1'b0;
    host_if.wr_valid  = 1'b0;
    host_if.wr_data   = 64'd0;
    host_if.rd_ready  = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_cmd_ready", 64'(host_if.cmd_ready), 64'd1);
    check("rst_busy",      64'(host_if.busy), 64'd0);
    check("rst_done",      64'(host_if.done), 64'd0);
    check("rst_cpu_en",    64'(cpu_enable), 64'd0);
    check("rst_wen",       64'({wen_ext, wen_ext_2, ren_ext_2, ren_ext}), 64'd0);
    check("rst_addr",      addr_ext | addr_ext_2, 64'd0);
    arst_n = 1'b1;
    tick();

    // LOAD_I len=3, back-to-back
    send_cmd(2'b00, 32'd3);
    check("li_busy", 64'(host_if.busy), 64'd1);
    check("li_wr_ready", 64'(host_if.wr_ready), 64'd1);
    host_if.wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_if.wr_data = {32'hFFFF_FFFF, imem_words[i]};
      tick();
      check("li_wen",   64'(wen_ext), 64'd1);
      check("li_addr",  addr_ext, 64'(i * 4));
      check("li_wdata", 64'(wdata_ext), 64'(imem_words[i]));
      check("li_wen2",  64'(wen_ext_2), 64'd0);
    end
    host_if.wr_valid = 1'b0;
    check("li_done_early", 64'(host_if.done), 64'd0);
    check("li_wr_ready_fin", 64'(host_if.wr_ready), 64'd0);
    tick();
    check("li_done", 64'(host_if.done), 64'd1);
    check("li_err",  64'(host_if.err), 64'd0);
    tick();
    check("li_done_pulse", 64'(host_if.done), 64'd0);
    check("li_idle", 64'(host_if.cmd_ready), 64'd1);

    // LOAD_D len=2 with 2-cycle gaps
    snap_wen = n_wen;
    send_cmd(2'b01, 32'd2);
    for (int i = 0; i < 2; i++) begin
      for (int g = 0; g < 2; g++) begin
        tick();
        check("ld_gap_wen2", 64'(wen_ext_2), 64'd0);
      end
      host_if.wr_valid = 1'b1;
      host_if.wr_data  = dmem_words[i];
      tick();
      host_if.wr_valid = 1'b0;
      check("ld_wen2",  64'(wen_ext_2), 64'd1);
      check("ld_addr",  addr_ext_2, 64'(i * 8));
      check("ld_wdata", wdata_ext_2, dmem_words[i]);
    end
    tick();
    check("ld_done", 64'(host_if.done), 64'd1);
    tick();
    check("ld_no_wen_i", 64'(n_wen - snap_wen), 64'd0);

    // RUN len=10
    snap_en = n_en; snap_wen = n_wen; snap_wen2 = n_wen2; snap_ren2 = n_ren2;
    send_cmd(2'b10, 32'd10);
    for (int i = 0; i < 10; i++) begin
      check("run_en", 64'(cpu_enable), 64'd1);
      tick();
    end
    check("run_en_off", 64'(cpu_enable), 64'd0);
    check("run_done",   64'(host_if.done), 64'd1);
    tick();
    check("run_en_count", 64'(n_en - snap_en), 64'd10);
    check("run_strobes", 64'((n_wen - snap_wen) + (n_wen2 - snap_wen2) + (n_ren2 - snap_ren2)), 64'd0);

    // RUN len=0
    snap_en = n_en;
    send_cmd(2'b10, 32'd0);
    check("run0_done", 64'(host_if.done), 64'd1);
    check("run0_err",  64'(host_if.err), 64'd0);
    tick();
    check("run0_en_count", 64'(n_en - snap_en), 64'd0);

    // DUMP_D len=2 with a 4-cycle stall on the first word
    snap_ren2 = n_ren2;
    send_cmd(2'b11, 32'd2);
    check("dmp_ren0",  64'(ren_ext_2), 64'd1);
    check("dmp_addr0", addr_ext_2, 64'd0);
    tick();
    check("dmp_wait_valid", 64'(host_if.rd_valid), 64'd0);
    tick();
    check("dmp_valid0", 64'(host_if.rd_valid), 64'd1);
    check("dmp_data0",  host_if.rd_data, 64'hDEAD);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dmp_stall_valid", 64'(host_if.rd_valid), 64'd1);
      check("dmp_stall_data",  host_if.rd_data, 64'hDEAD);
      check("dmp_stall_ren",   64'(ren_ext_2), 64'd0);
    end
    host_if.rd_ready = 1'b1;
    tick();
    host_if.rd_ready = 1'b0;
    check("dmp_ren1",   64'(ren_ext_2), 64'd1);
    check("dmp_addr1",  addr_ext_2, 64'd8);
    check("dmp_valid_off", 64'(host_if.rd_valid), 64'd0);
    tick(); tick();
    check("dmp_valid1", 64'(host_if.rd_valid), 64'd1);
    check("dmp_data1",  host_if.rd_data, 64'hBEEF);
    host_if.rd_ready = 1'b1;
    tick();
    host_if.rd_ready = 1'b0;
    check("dmp_done", 64'(host_if.done), 64'd1);
    check("dmp_valid_end", 64'(host_if.rd_valid), 64'd0);
    tick();
    check("dmp_ren_count", 64'(n_ren2 - snap_ren2), 64'd2);

    // LOAD_I len=129 exceeds depth
    snap_wen = n_wen;
    send_cmd(2'b00, 32'd129);
    check("ovf_done", 64'(host_if.done), 64'd1);
    check("ovf_err",  64'(host_if.err), 64'd1);
    tick();
    check("ovf_err_pulse", 64'(host_if.err), 64'd0);
    check("ovf_no_wen", 64'(n_wen - snap_wen), 64'd0);

    // Abort in the 5th RUN cycle
    snap_done = n_done;
    send_cmd(2'b10, 32'd20);
    for (int i = 0; i < 4; i++) tick();
    check("abt_en_before", 64'(cpu_enable), 64'd1);
    host_if.abort = 1'b1;
    tick();
    host_if.abort = 1'b0;
    check("abt_en",        64'(cpu_enable), 64'd0);
    check("abt_cmd_ready", 64'(host_if.cmd_ready), 64'd1);
    check("abt_busy",      64'(host_if.busy), 64'd0);
    for (int i = 0; i < 25; i++) tick();
    check("abt_no_done", 64'(n_done - snap_done), 64'd0);

    // Reset in the middle of a LOAD_D
    send_cmd(2'b01, 32'd4);
    host_if.wr_valid = 1'b1;
    host_if.wr_data  = 64'h1111_2222_3333_4444;
    tick();
    check("rml_wen2", 64'(wen_ext_2), 64'd1);
    snap_done = n_done;
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    host_if.wr_valid = 1'b0;
    check("rml_wen2_off",  64'(wen_ext_2), 64'd0);
    check("rml_cmd_ready", 64'(host_if.cmd_ready), 64'd1);
    check("rml_wr_ready",  64'(host_if.wr_ready), 64'd0);
    for (int i = 0; i < 3; i++) tick();
    check("rml_no_done", 64'(n_done - snap_done), 64'd0);

    // Next command runs normally
    send_cmd(2'b00, 32'd1);
    host_if.wr_valid = 1'b1;
    host_if.wr_data  = 64'h0000_0000_0000_CAFE;
    tick();
    host_if.wr_valid = 1'b0;
    check("post_wen",   64'(wen_ext), 64'd1);
    check("post_addr",  addr_ext, 64'd0);
    check("post_wdata", 64'(wdata_ext), 64'hCAFE);
    tick();
    check("post_done", 64'(host_if.done), 64'd1);
    tick();

    check("excl_violations", 64'(n_excl), 64'd0);
    check("ren_ext_never",   64'(n_ren_i), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
